// File: rtl/bram_port_master.sv
// bram_port_master: valid/ready initiator for one BRAM port.
// Requests drive the BRAM pins combinationally. Read data (1-cycle latency)
// is captured into a credit-controlled response FIFO.
// Optional build macro: BRAM_PORT_MASTER_STATS_EN adds the stat_rd/stat_wr counters.
module bram_port_master #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] req_wem,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              WE,
  output logic [DATA_W-1:0] WEM,
  output logic              CE,
  input  logic [DATA_W-1:0] Q
`ifdef BRAM_PORT_MASTER_STATS_EN
  ,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic              pend;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [CNT_W:0]    inflight;
  logic              acc;
  logic              push;
  logic              pop;

  // Credit gate: accept only while every outstanding read has a FIFO slot
  always_comb begin
    inflight  = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(pend);
    req_ready = ~RST & (32'(inflight) < FIFO_DEPTH);
    acc       = req_valid & req_ready;
  end

  // BRAM port pins follow the accepted request in the same cycle
  always_comb begin
    CE  = acc;
    A   = req_addr;
    D   = req_data;
    WE  = acc & req_we;
    WEM = (acc & req_we) ? req_wem : '0;
  end

  // FIFO handshake and response view
  always_comb begin
    push      = pend;
    rsp_valid = (cnt != '0);
    pop       = rsp_valid & rsp_ready;
    rsp_data  = mem[rd_ptr];
  end

  // Read-pending flag, occupancy and pointers (modulo FIFO_DEPTH)
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend   <= 1'b0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pend <= acc & ~req_we;
      if (push & ~pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (~push & pop) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Capture BRAM read data into the slot at wr_ptr
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= Q;
    end
  end

  // Credit rule makes a push into a full FIFO impossible
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && cnt == CNT_FULL));
    end
  end

`ifdef BRAM_PORT_MASTER_STATS_EN
  // Saturating counters of accepted reads and writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else begin
      if (acc & ~req_we & (stat_rd != 32'hFFFF_FFFF)) begin
        stat_rd <= stat_rd + 32'd1;
      end
      if (acc & req_we & (stat_wr != 32'hFFFF_FFFF)) begin
        stat_wr <= stat_wr + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: directed scenarios plus randomized traffic.
// Expected read data and timing come from a reference memory and a
// credit/ordering model; a separate checker pops expected responses.
module tb_bram_port_master;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned WORDS  = 1 << ADDR_W;

  logic              CLK;
  logic              RST;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_wem;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic              WE;
  logic [DATA_W-1:0] WEM;
  logic              CE;
  logic [DATA_W-1:0] Q;
`ifdef BRAM_PORT_MASTER_STATS_EN
  logic [31:0]       stat_rd;
  logic [31:0]       stat_wr;
`endif

  bram_port_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_wem(req_wem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .A(A), .D(D), .WE(WE), .WEM(WEM), .CE(CE), .Q(Q)
`ifdef BRAM_PORT_MASTER_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic preload;

  logic [DATA_W-1:0] bram    [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] exp_data[$];
  int                exp_cyc [$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural BRAM on the port: sequential write, 1-cycle read
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < int'(WORDS); i++) bram[i] <= 8'(i);
    end else if (CE) begin
      if (WE) bram[A] <= (bram[A] & ~WEM) | (D & WEM);
      else    Q <= bram[A];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Request-side model: credit rule, pin values, expected read data
  always @(negedge CLK) begin
    bit exp_rdy;
    bit acc;
    if (RST) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_ce", 32'(CE), 32'd0);
      chk("rst_we", 32'(WE), 32'd0);
      chk("rst_wem", 32'(WEM), 32'd0);
      exp_data.delete();
      exp_cyc.delete();
      rd_cnt = 0;
      wr_cnt = 0;
      if (preload) begin
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = 8'(i);
      end
    end else begin
      exp_rdy = (exp_data.size() < int'(DEPTH));
      acc     = req_valid && exp_rdy;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("ce", 32'(CE), 32'(acc));
      chk("we", 32'(WE), 32'(acc && req_we));
      chk("wem", 32'(WEM), (acc && req_we) ? 32'(req_wem) : 32'd0);
      if (acc) begin
        chk("addr", 32'(A), 32'(req_addr));
        if (req_we) begin
          chk("wdata", 32'(D), 32'(req_data));
          ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wem) | (req_data & req_wem);
          wr_cnt++;
        end else begin
          exp_data.push_back(ref_mem[req_addr]);
          exp_cyc.push_back(cyc);
          rd_cnt++;
        end
      end
    end
  end

  // Response checker: in-order data, valid exactly from accept+2
  always begin
    bit exp_v;
    @(negedge CLK);
    #2;
    if (!RST) begin
      exp_v = (exp_data.size() > 0) && (exp_cyc[0] + 2 <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (rsp_valid && exp_v) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_data[0]));
        if (rsp_ready) begin
          void'(exp_data.pop_front());
          void'(exp_cyc.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded)
  task automatic send(input bit we, input int addr, input int data, input int wem);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_data  = DATA_W'(data);
    req_wem   = DATA_W'(wem);
    @(negedge CLK);
    while (!req_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL send_timeout: got no req_ready expected acceptance (addr %0d)", addr);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    RST = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_wem = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 preload = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(2);

    // Full throughput: 16 back-to-back reads of data=addr
    for (int i = 0; i < 16; i++) send(1'b0, i, 0, 0);
    idle(4);

    // Write then read the same address in the next cycle
    send(1'b1, 5, 8'hA5, 8'hFF);
    send(1'b0, 5, 0, 0);
    idle(4);

    // Backpressure: only DEPTH reads accepted while rsp_ready is low
    rsp_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(32 + i);
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    chk("bp_accepts", 32'(rd_cnt - r0), 32'(DEPTH));
    idle(3);
    rsp_ready = 1'b1;
    idle(6);

    // Partial write mask
    send(1'b1, 3, 8'hFF, 8'hFF);
    send(1'b1, 3, 8'h00, 8'h0F);
    send(1'b0, 3, 0, 0);
    idle(4);

    // Reset with two reads in flight
    send(1'b0, 7, 0, 0);
    send(1'b0, 8, 0, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(6);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom % 4) != 0;
      req_we    = ($urandom % 3) == 0;
      req_addr  = ADDR_W'($urandom % 16);
      req_data  = DATA_W'($urandom);
      req_wem   = DATA_W'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(8);
    chk("drained", 32'(exp_data.size()), 32'd0);

`ifdef BRAM_PORT_MASTER_STATS_EN
    chk("stat_rd", stat_rd, 32'(rd_cnt));
    chk("stat_wr", stat_wr, 32'(wr_cnt));
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(1);
    chk("stat_rd_rst", stat_rd, 32'd0);
    chk("stat_wr_rst", stat_wr, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
